// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: packet size limit, scheduler state encoding,
// default timing constants and the packet length clamp.
package rs232_pkg;

    localparam int MAX_BYTES          = 6;
    localparam int GAP_CYCLES_DEF     = 40;
    localparam int ACCEPT_TIMEOUT_DEF = 64;
    localparam int DONE_TIMEOUT_DEF   = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_ACCEPT,
        ST_WAIT_DONE,
        ST_GAP
    } sched_state_t;

    // Oversized requests are truncated to what the encoder can frame.
    function automatic logic [3:0] clamp_len(input logic [3:0] n);
        return (n > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// the pointer wins, wrapping around.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] idx_o,
    output logic           valid_o
);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                grant_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/rs232_tx_scheduler.sv
// Shares the single RS-232 transmit path between NUM_REQ packet sources with
// round-robin arbitration, an inter-packet gap and accept/done watchdogs.
module rs232_tx_scheduler
    import rs232_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int ACCEPT_TIMEOUT = ACCEPT_TIMEOUT_DEF,
    parameter int DONE_TIMEOUT   = DONE_TIMEOUT_DEF,
    localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clock_00_0384,
    input  logic                           reset_c,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_bytes,
    input  logic [NUM_REQ*4-1:0]           req_num_bytes,
    output logic [NUM_REQ-1:0]             ack,
    output logic [MAX_BYTES*8-1:0]         tx_bytes,
    output logic [3:0]                     tx_num_bytes,
    output logic                           tx_valid,
    input  logic                           tx_busy,
    output logic [IDW-1:0]                 grant_id,
    output logic                           timeout_err,
    input  logic                           err_clear
);

    sched_state_t            state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          grant_id_q, grant_id_d;
    logic [MAX_BYTES*8-1:0]  tx_bytes_q, tx_bytes_d;
    logic [3:0]              tx_num_q, tx_num_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic                    err_q, err_d, err_set;
    logic                    busy_m_q, busy_s_q;

    logic [NUM_REQ-1:0]      arb_grant;
    logic [IDW-1:0]          arb_idx;
    logic                    arb_valid;
    logic [MAX_BYTES*8-1:0]  sel_bytes;
    logic [3:0]              sel_num;

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign sel_bytes = req_bytes[arb_idx*(MAX_BYTES*8) +: MAX_BYTES*8];
    assign sel_num   = req_num_bytes[arb_idx*4 +: 4];

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        return (i == IDW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        tx_bytes_d = tx_bytes_q;
        tx_num_d   = tx_num_q;
        tx_valid_d = tx_valid_q;
        ack_d      = '0;
        err_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arb_valid) begin
                    grant_id_d = arb_idx;
                    tx_bytes_d = sel_bytes;
                    tx_num_d   = clamp_len(sel_num);
                    if (sel_num == 4'd0) begin
                        ack_d   = arb_grant;
                        ptr_d   = wrap_inc(arb_idx);
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                tx_valid_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (busy_s_q) begin
                    tx_valid_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_WAIT_DONE;
                end else if (cnt_q == 16'(ACCEPT_TIMEOUT - 1)) begin
                    tx_valid_d          = 1'b0;
                    err_set             = 1'b1;
                    ack_d[grant_id_q]   = 1'b1;
                    ptr_d               = wrap_inc(grant_id_q);
                    cnt_d               = '0;
                    state_d             = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                // A completed frame and a stuck-busy timeout both release the source.
                if (!busy_s_q || cnt_q == 16'(DONE_TIMEOUT - 1)) begin
                    err_set           = busy_s_q;
                    ack_d[grant_id_q] = 1'b1;
                    ptr_d             = wrap_inc(grant_id_q);
                    cnt_d             = '0;
                    state_d           = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d      = '0;
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
        // A same-cycle timeout outranks the clear.
        err_d = err_set ? 1'b1 : (err_clear ? 1'b0 : err_q);
    end

    always_ff @(posedge clock_00_0384 or posedge reset_c) begin
        if (reset_c) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            grant_id_q <= '0;
            tx_bytes_q <= '0;
            tx_num_q   <= '0;
            tx_valid_q <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            busy_m_q   <= 1'b0;
            busy_s_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            tx_bytes_q <= tx_bytes_d;
            tx_num_q   <= tx_num_d;
            tx_valid_q <= tx_valid_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_m_q   <= tx_busy;
            busy_s_q   <= busy_m_q;
        end
    end

    assign ack          = ack_q;
    assign tx_bytes     = tx_bytes_q;
    assign tx_num_bytes = tx_num_q;
    assign tx_valid     = tx_valid_q;
    assign grant_id     = grant_id_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// Directed bench for rs232_tx_scheduler: single packet, accept/done timeouts,
// length edges, two-source contention and reset during a transfer.
module tb_rs232_tx_scheduler;

    logic        clock_00_0384;
    logic        reset_c;
    logic [1:0]  req;
    logic [95:0] req_bytes;
    logic [7:0]  req_num_bytes;
    logic [1:0]  ack;
    logic [47:0] tx_bytes;
    logic [3:0]  tx_num_bytes;
    logic        tx_valid;
    logic        tx_busy;
    logic [0:0]  grant_id;
    logic        timeout_err;
    logic        err_clear;

    int n_total = 0;
    int n_bad   = 0;
    int ack_pulses = 0;

    rs232_tx_scheduler dut (
        .clock_00_0384 (clock_00_0384),
        .reset_c       (reset_c),
        .req           (req),
        .req_bytes     (req_bytes),
        .req_num_bytes (req_num_bytes),
        .ack           (ack),
        .tx_bytes      (tx_bytes),
        .tx_num_bytes  (tx_num_bytes),
        .tx_valid      (tx_valid),
        .tx_busy       (tx_busy),
        .grant_id      (grant_id),
        .timeout_err   (timeout_err),
        .err_clear     (err_clear)
    );

    // ---------------- clock / reset ----------------
    initial clock_00_0384 = 1'b0;
    always #5 clock_00_0384 = ~clock_00_0384;

    always @(negedge clock_00_0384) ack_pulses += $countones(ack);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock_00_0384);
    endtask

    task automatic set_src(input int i, input logic [47:0] b, input logic [3:0] n);
        req_bytes[i*48 +: 48]  = b;
        req_num_bytes[i*4 +: 4] = n;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!tx_valid && k < 200) begin
            tick(1);
            k++;
        end
        check("valid_up", tx_valid, 1);
    endtask

    // Encoder model: busy rises dly cycles after tx_valid is seen, stays hold cycles.
    task automatic encode(input int dly, input int hold, output logic [1:0] a);
        int k;
        wait_valid();
        tick(dly);
        tx_busy = 1'b1;
        tick(hold);
        tx_busy = 1'b0;
        k = 0;
        while (ack == 2'b00 && k < 20) begin
            tick(1);
            k++;
        end
        a = ack;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] a;
        int k;
        int bad_cycles;

        reset_c = 1'b1;
        req = '0;
        req_bytes = '0;
        req_num_bytes = '0;
        tx_busy = 1'b0;
        err_clear = 1'b0;
        tick(3);
        reset_c = 1'b0;
        tick(1);
        check("rst_ack", ack, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_num", tx_num_bytes, 0);
        check("rst_bytes", tx_bytes, 0);
        check("rst_gid", grant_id, 0);
        check("rst_err", timeout_err, 0);

        // Single packet on source 0.
        set_src(0, 48'h0A0D41, 4'd3);
        req = 2'b01;
        tick(1);
        check("sp_valid_grant", tx_valid, 0);
        check("sp_num", tx_num_bytes, 3);
        check("sp_bytes", tx_bytes, 48'h0A0D41);
        check("sp_gid", grant_id, 0);
        tick(1);
        check("sp_valid_rise", tx_valid, 1);
        tick(4);
        tx_busy = 1'b1;
        ack_pulses = 0;
        tick(120);
        check("sp_no_early_ack", ack_pulses, 0);
        check("sp_valid_drop", tx_valid, 0);
        tx_busy = 1'b0;
        // busy_s lags tx_busy by two edges; ack is registered one edge later.
        tick(2);
        check("sp_ack_early", ack, 0);
        tick(1);
        check("sp_ack", ack, 2'b01);

        // Immediate re-request: held off for the full gap, then times out on accept.
        set_src(0, 48'h4243, 4'd2);
        tick(1);
        check("sp_ack_single", ack, 0);
        bad_cycles = 0;
        for (int i = 0; i < 39; i++) begin
            if (tx_num_bytes != 4'd3) bad_cycles++;
            tick(1);
        end
        check("gap_no_grant", bad_cycles, 0);
        check("gap_num_hold", tx_num_bytes, 3);
        tick(1);
        check("gap_grant", tx_num_bytes, 2);
        tick(1);
        k = 0;
        while (tx_valid && k < 200) begin
            k++;
            tick(1);
        end
        check("at_valid_len", k, 64);
        check("at_ack", ack, 2'b01);
        check("at_err", timeout_err, 1);
        req = 2'b00;
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("at_err_clear", timeout_err, 0);

        // Zero-length request on source 1: ack without transmit.
        tick(41);
        set_src(1, 48'h55, 4'd0);
        req = 2'b10;
        tick(1);
        check("z_ack", ack, 2'b10);
        check("z_gid", grant_id, 1);
        check("z_valid", tx_valid, 0);
        req = 2'b00;
        bad_cycles = 0;
        for (int i = 0; i < 41; i++) begin
            tick(1);
            if (tx_valid) bad_cycles++;
        end
        check("z_never_valid", bad_cycles, 0);

        // Contention: both sources keep requesting; grants alternate 0,1,0,1.
        set_src(0, 48'h30, 4'd1);
        set_src(1, 48'h3132, 4'd2);
        req = 2'b11;
        ack_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            wait_valid();
            check("ct_gid", grant_id, i % 2);
            check("ct_num", tx_num_bytes, (i % 2) ? 2 : 1);
            encode(2, 8, a);
            check("ct_ack", a, (i % 2) ? 2'b10 : 2'b01);
        end
        req = 2'b00;
        tick(2);
        check("ct_ack_count", ack_pulses, 4);

        // Oversized length is clamped.
        tick(41);
        set_src(0, 48'h665544332211, 4'd9);
        req = 2'b01;
        tick(1);
        check("cl_num", tx_num_bytes, 6);
        check("cl_bytes", tx_bytes, 48'h665544332211);
        encode(2, 10, a);
        check("cl_ack", a, 2'b01);
        req = 2'b00;

        // Done timeout: busy stuck high.
        tick(41);
        set_src(1, 48'h44434241, 4'd4);
        req = 2'b10;
        wait_valid();
        tx_busy = 1'b1;
        k = 0;
        while (tx_valid && k < 20) begin
            tick(1);
            k++;
        end
        check("dt_accept", tx_valid, 0);
        k = 0;
        do begin
            tick(1);
            k++;
        end while (ack == 2'b00 && k < 1100);
        check("dt_latency", k, 1024);
        check("dt_ack", ack, 2'b10);
        check("dt_err", timeout_err, 1);
        tx_busy = 1'b0;
        req = 2'b00;
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("dt_err_clear", timeout_err, 0);

        // Next request is still served after the timeout.
        tick(41);
        set_src(0, 48'h61, 4'd1);
        req = 2'b01;
        encode(2, 5, a);
        check("dt_next_ack", a, 2'b01);
        check("dt_next_err", timeout_err, 0);
        req = 2'b00;

        // Reset during WAIT_DONE, then source 1 pending wins from pointer 0.
        tick(41);
        set_src(1, 48'h7172, 4'd2);
        req = 2'b10;
        wait_valid();
        check("rm_gid_pre", grant_id, 1);
        tx_busy = 1'b1;
        k = 0;
        while (tx_valid && k < 20) begin
            tick(1);
            k++;
        end
        reset_c = 1'b1;
        #1;
        check("rm_valid", tx_valid, 0);
        check("rm_num", tx_num_bytes, 0);
        check("rm_bytes", tx_bytes, 0);
        check("rm_gid", grant_id, 0);
        check("rm_ack", ack, 0);
        tx_busy = 1'b0;
        set_src(1, 48'h737475767778, 4'd5);
        req = 2'b10;
        tick(1);
        reset_c = 1'b0;
        tick(1);
        check("rm_regrant_gid", grant_id, 1);
        check("rm_regrant_num", tx_num_bytes, 5);
        tick(1);
        check("rm_regrant_valid", tx_valid, 1);
        req = 2'b00;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
